// File: rtl/countdown_scheduler.sv
// countdown_scheduler: time-shares one external down counter among NUM_REQ
// requesters. Round-robin arbitration picks a winner, the counter is loaded with
// that requester's value and decremented until it reports zero, and the winner
// then receives a one-cycle done pulse.
module countdown_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_val,
  input  logic                       hold,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [WIDTH-1:0]           cnt_in,
  output logic                       cnt_latch,
  output logic                       cnt_dec,
  input  logic                       cnt_zero
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  winner_q;
  logic [IW-1:0]                  ptr_q;
  logic [NUM_REQ-1:0]             grant_q;
  logic [WIDTH-1:0]               cnt_in_q;

  // Per-requester view of the flat load-value bus.
  logic [NUM_REQ-1:0][WIDTH-1:0]  vals;
  assign vals = req_val;

  logic                           pick_vld;
  logic [IW-1:0]                  pick_idx;

  // Round-robin pick: scan from the pointer upward with wrap. The scan runs
  // from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(idx);
      end
    end
  end

  // Next-state logic; the counter's zero flag is the only exit from RUN, so
  // hold never changes the state, it only gates the decrement.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (cnt_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any service in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Winner, grant and load value are captured once at the grant edge and held
  // through DONE, so later req/req_val changes cannot disturb the service.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner_q <= '0;
      grant_q  <= '0;
      cnt_in_q <= '0;
    end else if (state_q == IDLE && pick_vld) begin
      winner_q <= pick_idx;
      grant_q  <= NUM_REQ'(1) << pick_idx;
      cnt_in_q <= vals[pick_idx];
    end else if (state_q == DONE) begin
      grant_q  <= '0;
    end
  end

  // Pointer moves just past the served requester so a continuously requesting
  // agent yields to every other one before being granted again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (state_q == DONE) begin
      if (winner_q == IW'(NUM_REQ - 1)) ptr_q <= '0;
      else                              ptr_q <= winner_q + 1'b1;
    end
  end

  // Done pulse decoded per requester from the DONE state and the winner.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_done
      assign done[gi] = (state_q == DONE) && (winner_q == IW'(gi));
    end
  endgenerate

  assign grant     = grant_q;
  assign cnt_in    = cnt_in_q;
  assign busy      = (state_q != IDLE);
  assign cnt_latch = (state_q == LOAD);
  // Only combinational path: never decrement past zero, and pause on hold.
  assign cnt_dec   = (state_q == RUN) && !cnt_zero && !hold;

endmodule

// File: tb/tb_countdown_scheduler.sv
// Bench for countdown_scheduler: directed test-plan steps followed by random
// traffic, all checked every cycle against a service-level reference model.
module tb_countdown_scheduler;
  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_val = '0;
  logic           hold = 1'b0;
  logic [N-1:0]   grant, done;
  logic           busy, cnt_latch, cnt_dec, cnt_zero;
  logic [W-1:0]   cnt_in;
  logic [W-1:0]   cnt = '0;

  int n_tests = 0, n_fail = 0, n_edges = 0, dec_cycles = 0;

  // Service-level model: one service at a time, described by winner, value,
  // cycles since the sampling edge and decrements still owed.
  bit m_busy = 0, m_fin = 0;
  int m_w = 0, m_v = 0, m_age = 0, m_left = 0, m_ptr = 0;

  countdown_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_val(req_val), .hold(hold),
    .grant(grant), .done(done), .busy(busy), .cnt_in(cnt_in),
    .cnt_latch(cnt_latch), .cnt_dec(cnt_dec), .cnt_zero(cnt_zero)
  );

  always #5 clk = ~clk;

  // External shared down counter (not reset by the scheduler's reset).
  always @(posedge clk) begin
    if (cnt_latch)    cnt <= cnt_in;
    else if (cnt_dec) cnt <= cnt - 1'b1;
  end
  assign cnt_zero = (cnt == '0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare this cycle against the model, advance the model with the inputs
  // that the next rising edge will sample, then move to the next falling edge.
  task automatic step();
    bit found;
    found = 0;
    #1;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant", 32'(grant), m_busy ? (32'd1 << m_w) : 32'd0);
    chk("done", 32'(done), (m_busy && m_fin) ? (32'd1 << m_w) : 32'd0);
    chk("cnt_latch", 32'(cnt_latch), 32'(m_busy && m_age == 1));
    chk("cnt_dec", 32'(cnt_dec), 32'(m_busy && m_age >= 2 && !m_fin && m_left > 0 && !hold));
    chk("latch_dec_excl", 32'(cnt_latch & cnt_dec), 32'd0);
    if (m_busy) chk("cnt_in", 32'(cnt_in), 32'(m_v));
    if (m_busy && m_age >= 2 && !m_fin) chk("count", 32'(cnt), 32'(m_left));
    if (cnt_dec) dec_cycles++;
    if (!m_busy) begin
      if (req != '0) begin
        for (int k = 0; k < N; k++)
          if (!found && req[(m_ptr + k) % N]) begin
            found = 1;
            m_w = (m_ptr + k) % N;
          end
        m_busy = 1; m_fin = 0; m_age = 1;
        m_v = int'(req_val[m_w*W +: W]);
        m_left = m_v;
      end
    end else if (m_fin) begin
      m_busy = 0;
      m_ptr = (m_w + 1) % N;
    end else begin
      if (m_age >= 2) begin
        if (m_left == 0) m_fin = 1;
        else if (!hold)  m_left--;
      end
      m_age++;
    end
    @(posedge clk);
    n_edges++;
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt_in", 32'(cnt_in), 32'd0);
    chk("rst_latch", 32'(cnt_latch), 32'd0);
    chk("rst_dec", 32'(cnt_dec), 32'd0);
    m_busy = 0; m_fin = 0; m_ptr = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int exp_edges, input string tag);
    while (done == '0 && n_edges < 60) step();
    chk(tag, 32'(n_edges), 32'(exp_edges));
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // V=5 on requester 0: done 8 edges after sampling, 5 decrements.
    req = 4'b0001; req_val = 16'h0005; n_edges = 0; dec_cycles = 0;
    step();
    req = '0;
    chk("t1_grant", 32'(grant), 32'h1);
    wait_done(8, "t1_latency");
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_decs", 32'(dec_cycles), 32'd5);
    step();
    chk("t1_busy_fall", 32'(busy), 32'd0);

    // V=0 on requester 2: no decrements, done 3 edges after sampling.
    req = 4'b0100; req_val = 16'h0000; n_edges = 0; dec_cycles = 0;
    step();
    req = '0;
    wait_done(3, "t2_latency");
    chk("t2_done", 32'(done), 32'h4);
    chk("t2_decs", 32'(dec_cycles), 32'd0);
    step();

    // All four requesting continuously: round-robin 0,1,2,3,0.
    do_reset();
    req = 4'b1111; req_val = 16'h2222;
    for (int s = 0; s < 5; s++) begin
      n_edges = 0;
      wait_done(5, "t3_latency");
      chk("t3_grant", 32'(grant), 32'd1 << (s % 4));
      chk("t3_done", 32'(done), 32'd1 << (s % 4));
      step();
      chk("t3_idle_gap", 32'(busy), 32'd0);
    end
    req = '0;

    // Hold for 3 cycles mid-RUN on requester 1, V=4: latency 10.
    req = 4'b0010; req_val = 16'h0040; n_edges = 0;
    step();
    req = '0;
    step();
    step();
    hold = 1'b1;
    step(); step(); step();
    chk("t4_count_held", 32'(cnt), 32'd3);
    hold = 1'b0;
    wait_done(10, "t4_latency");
    chk("t4_done", 32'(done), 32'h2);
    step();

    // Reset during the 4th RUN cycle of requester 3 (V=9): no done afterwards.
    do_reset();
    req = 4'b1000; req_val = 16'h9000;
    step();
    req = '0;
    step(); step(); step(); step();
    do_reset();
    step(); step();
    chk("t5_no_done", 32'(done), 32'd0);
    req = 4'b1000; req_val = 16'h3000; n_edges = 0;
    step();
    req = '0;
    chk("t5_regrant", 32'(grant), 32'h8);
    chk("t5_reload", 32'(cnt_in), 32'd3);
    wait_done(6, "t5_latency");
    step();

    // Requester 0 drops req and changes its value right after the grant.
    req = 4'b0001; req_val = 16'h0006; n_edges = 0;
    step();
    req = '0; req_val = 16'h000F;
    wait_done(9, "t6_latency");
    chk("t6_done", 32'(done), 32'h1);
    chk("t6_captured", 32'(cnt_in), 32'd6);
    step();

    // Random traffic, including hold and req_val churn during service.
    for (int i = 0; i < 600; i++) begin
      req     = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      req_val = (N*W)'($urandom);
      hold    = ($urandom_range(0, 3) == 0);
      step();
    end
    req = '0; hold = 1'b0;
    for (int i = 0; i < 40 && busy; i++) step();
    chk("drain_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
